// File: rtl/qadd_accum_ctrl_pkg.sv
// Shared defaults, state encoding and sign-magnitude helpers for the accumulator controller.
package qadd_accum_ctrl_pkg;

   localparam int unsigned Q_DEF  = 15;
   localparam int unsigned N_DEF  = 32;
   localparam int unsigned CW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest positive sign-magnitude value at the default width (magnitude all ones).
   localparam logic [N_DEF-1:0] SM_MAX = {1'b0, {(N_DEF-1){1'b1}}};

   // Map negative zero to positive zero; every other code passes unchanged.
   function automatic logic [N_DEF-1:0] sm_negzero(input logic [N_DEF-1:0] x);
      if (x[N_DEF-1] && (x[N_DEF-2:0] == '0)) begin
         return '0;
      end
      return x;
   endfunction

endpackage

// File: rtl/qadd_accum_ctrl_qadd.sv
// Combinational sign-magnitude Q-format adder; no overflow detection.
module qadd #(
   parameter int unsigned Q = 15,
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c
);

   // The fractional position does not change the adder; reject impossible formats.
   if (Q > N - 1) begin : g_bad_q
      $error("qadd: Q must not exceed N-1");
   end

   logic [N-2:0] mag_a;
   logic [N-2:0] mag_b;
   logic [N-2:0] diff_ba;

   assign mag_a   = a[N-2:0];
   assign mag_b   = b[N-2:0];
   assign diff_ba = mag_b - mag_a;

   // Same signs add magnitudes; opposite signs subtract the smaller from the larger.
   always_comb begin
      c = '0;
      if (a[N-1] == b[N-1]) begin
         c[N-2:0] = mag_a + mag_b;
         c[N-1]   = a[N-1];
      end else if (mag_a > mag_b) begin
         c[N-2:0] = mag_a - mag_b;
         c[N-1]   = a[N-1];
      end else begin
         c[N-2:0] = diff_ba;
         c[N-1]   = (diff_ba != '0) ? b[N-1] : 1'b0;
      end
   end

endmodule

// File: rtl/qadd_accum_ctrl.sv
// Sequenced sign-magnitude accumulator: sums len samples through one qadd with saturation.
module qadd_accum_ctrl
   import qadd_accum_ctrl_pkg::*;
#(
   parameter int unsigned Q  = Q_DEF,
   parameter int unsigned N  = N_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          abort,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          ovf
);

   state_t        state;
   state_t        state_nx;
   logic [N-1:0]  acc;
   logic [N-1:0]  acc_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          ovf_nx;
   logic          in_ready_nx;
   logic          out_valid_nx;
   logic          busy_nx;
   logic [N-1:0]  out_data_nx;

   logic [N-1:0]  samp_c;
   logic [N-1:0]  sum_c;
   logic          ovf_det_c;
   logic [N-1:0]  sat_c;

   // Negative zero is folded to +0 before it reaches the adder.
   assign samp_c = (in_data[N-1] && (in_data[N-2:0] == '0)) ? '0 : in_data;

   qadd #(
      .Q (Q),
      .N (N)
   ) u_qadd (
      .a (acc),
      .b (samp_c),
      .c (sum_c)
   );

   // Same-sign addition whose magnitude shrank has wrapped; clamp to full scale.
   always_comb begin
      ovf_det_c = (acc[N-1] == samp_c[N-1]) && (sum_c[N-2:0] < acc[N-2:0]);
      sat_c     = sum_c;
      if (ovf_det_c) begin
         sat_c = {acc[N-1], {(N-1){1'b1}}};
      end
   end

   // Next-state, datapath and Moore-output decode; abort overrides everything.
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      cnt_nx   = cnt;
      ovf_nx   = ovf;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc_nx   = '0;
                  ovf_nx   = 1'b0;
                  cnt_nx   = len;
                  state_nx = (len == '0) ? DONE : ACC;
               end
            end
            ACC: begin
               if (in_valid && in_ready) begin
                  acc_nx = sat_c;
                  ovf_nx = ovf | ovf_det_c;
                  cnt_nx = CW'(cnt - CW'(1));
                  if (cnt == CW'(1)) begin
                     state_nx = DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_nx = IDLE;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
      in_ready_nx  = (state_nx == ACC);
      out_valid_nx = (state_nx == DONE);
      busy_nx      = (state_nx != IDLE);
      out_data_nx  = (state_nx == DONE) ? acc_nx : '0;
   end

   // State, datapath and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         cnt       <= cnt_nx;
         ovf       <= ovf_nx;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
         busy      <= busy_nx;
         out_data  <= out_data_nx;
      end
   end

endmodule

// File: tb/tb_qadd_accum_ctrl.sv
// Directed self-checking bench for qadd_accum_ctrl.
module tb_qadd_accum_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        abort;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        ovf;

   int compared;
   int mismatched;

   qadd_accum_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      len   = 8'hAA;
   endtask

   task automatic feed(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = 32'h0;
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      compared++;
      if ({busy, in_ready, out_valid, ovf} !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_flags: got %b want 0000", {busy, in_ready, out_valid, ovf});
      end
      compared++;
      if (out_data !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_data: got %h want 00000000", out_data);
      end
   endtask

   task automatic test_basic();
      do_start(8'd3);
      compared++;
      if ({busy, in_ready, out_valid} !== 3'b110) begin
         mismatched++;
         $display("FAIL basic_after_start: got %b want 110", {busy, in_ready, out_valid});
      end
      feed(32'h0000_8000);
      feed(32'h0000_4000);
      compared++;
      if ({in_ready, out_valid} !== 2'b10) begin
         mismatched++;
         $display("FAIL basic_mid: got %b want 10", {in_ready, out_valid});
      end
      feed(32'h8000_C000);
      compared++;
      if ({busy, in_ready, out_valid, ovf} !== 4'b1010) begin
         mismatched++;
         $display("FAIL basic_done_flags: got %b want 1010", {busy, in_ready, out_valid, ovf});
      end
      compared++;
      if (out_data !== 32'h0000_0000) begin
         mismatched++;
         $display("FAIL basic_sum: got %h want 00000000", out_data);
      end
      take();
      compared++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         mismatched++;
         $display("FAIL basic_handoff: got %b want 000", {busy, in_ready, out_valid});
      end
   endtask

   task automatic test_zero_len();
      do_start(8'd0);
      compared++;
      if ({busy, in_ready, out_valid, ovf} !== 4'b1010) begin
         mismatched++;
         $display("FAIL zero_flags: got %b want 1010", {busy, in_ready, out_valid, ovf});
      end
      compared++;
      if (out_data !== 32'h0) begin
         mismatched++;
         $display("FAIL zero_data: got %h want 00000000", out_data);
      end
      // A start presented in the handoff cycle must not open a new run.
      start     = 1'b1;
      len       = 8'd2;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      compared++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         mismatched++;
         $display("FAIL zero_no_back_to_back: got %b want 000", {busy, in_ready, out_valid});
      end
   endtask

   task automatic test_saturation();
      do_start(8'd2);
      feed(32'h7FFF_FFFF);
      feed(32'h0000_0001);
      compared++;
      if ({out_valid, ovf} !== 2'b11) begin
         mismatched++;
         $display("FAIL sat_pos_flags: got %b want 11", {out_valid, ovf});
      end
      compared++;
      if (out_data !== 32'h7FFF_FFFF) begin
         mismatched++;
         $display("FAIL sat_pos_data: got %h want 7fffffff", out_data);
      end
      take();
      do_start(8'd2);
      compared++;
      if (ovf !== 1'b0) begin
         mismatched++;
         $display("FAIL sat_ovf_cleared: got %b want 0", ovf);
      end
      feed(32'hFFFF_FFFF);
      feed(32'h8000_0001);
      compared++;
      if ({out_valid, ovf} !== 2'b11) begin
         mismatched++;
         $display("FAIL sat_neg_flags: got %b want 11", {out_valid, ovf});
      end
      compared++;
      if (out_data !== 32'hFFFF_FFFF) begin
         mismatched++;
         $display("FAIL sat_neg_data: got %h want ffffffff", out_data);
      end
      take();
   endtask

   task automatic test_stall();
      logic        vpat [7];
      logic [31:0] dpat [7];
      logic [31:0] held;
      vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      dpat = '{32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 32'h0000_4000,
               32'h0000_2000, 32'h0004_0000, 32'h8000_1000};
      do_start(8'd4);
      for (int i = 0; i < 7; i++) begin
         in_valid = vpat[i];
         in_data  = dpat[i];
         tick();
         if (i == 5) begin
            compared++;
            if ({in_ready, out_valid} !== 2'b10) begin
               mismatched++;
               $display("FAIL stall_gap_holds: got %b want 10", {in_ready, out_valid});
            end
         end
      end
      in_valid = 1'b0;
      compared++;
      if ({in_ready, out_valid} !== 2'b01) begin
         mismatched++;
         $display("FAIL stall_done: got %b want 01", {in_ready, out_valid});
      end
      // 1.0 + 0.5 + 0.25 - 0.125 = 1.625
      compared++;
      if (out_data !== 32'h0000_D000) begin
         mismatched++;
         $display("FAIL stall_sum: got %h want 0000d000", out_data);
      end
      held = 32'h0000_D000;
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         len   = 8'd7;
         tick();
         start = 1'b0;
         compared++;
         if ({out_valid, out_data} !== {1'b1, held}) begin
            mismatched++;
            $display("FAIL stall_hold_%0d: got %b/%h want 1/%h", c, out_valid, out_data, held);
         end
      end
      take();
      compared++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         mismatched++;
         $display("FAIL stall_start_ignored: got %b want 000", {busy, in_ready, out_valid});
      end
   endtask

   task automatic test_abort();
      do_start(8'd5);
      feed(32'h0000_8000);
      feed(32'h0000_8000);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h0000_1000;
      start    = 1'b1;
      len      = 8'd3;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      start    = 1'b0;
      compared++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         mismatched++;
         $display("FAIL abort_idle: got %b want 000", {busy, in_ready, out_valid});
      end
      compared++;
      if (out_data !== 32'h0) begin
         mismatched++;
         $display("FAIL abort_data: got %h want 00000000", out_data);
      end
      tick();
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL abort_no_valid: got %b want 0", out_valid);
      end
      do_start(8'd1);
      feed(32'h8000_0000);
      compared++;
      if ({out_valid, ovf} !== 2'b10) begin
         mismatched++;
         $display("FAIL negzero_flags: got %b want 10", {out_valid, ovf});
      end
      compared++;
      if (out_data !== 32'h0000_0000) begin
         mismatched++;
         $display("FAIL negzero_data: got %h want 00000000", out_data);
      end
      take();
   endtask

   task automatic test_rst_in_done();
      do_start(8'd1);
      feed(32'h0000_8000);
      compared++;
      if ({out_valid, out_data} !== {1'b1, 32'h0000_8000}) begin
         mismatched++;
         $display("FAIL rst_pre_done: got %b/%h want 1/00008000", out_valid, out_data);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      compared++;
      if ({busy, in_ready, out_valid, ovf, out_data} !== {4'b0000, 32'h0}) begin
         mismatched++;
         $display("FAIL rst_in_done: got %b/%h want 0000/00000000",
                  {busy, in_ready, out_valid, ovf}, out_data);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      start      = 1'b0;
      len        = 8'd0;
      abort      = 1'b0;
      in_data    = 32'h0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_zero_len();
      test_saturation();
      test_stall();
      test_abort();
      test_rst_in_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/qadd_accum_ctrl.md
# qadd_accum_ctrl

Sequenced accumulator controller that streams sign-magnitude Q-format samples through one shared `qadd` instance. It sums a programmed number of samples into a single result. It sits ahead of the LPC/energy stages of the Codec2 encoder, replacing ad-hoc adder trees. It adds valid/ready handshaking, a length counter, saturation on overflow (which `qadd` does not detect), and abort.

## Interface
- Q, 15, fractional bits of the sign-magnitude format
- N, 32, word width; bit N-1 is sign, bits N-2:0 are magnitude
- CW, 8, width of the length field; maximum run length is 2^CW-1
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- len  in  CW  number of samples in the run; captured with start
- abort  in  1  synchronous abandon of the current run
- in_data  in  N  sign-magnitude sample
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  N  sign-magnitude sum
- out_valid  out  1  out_data is valid; held until taken
- out_ready  in  1  consumer takes out_data
- busy  out  1  high in any state other than IDLE
- ovf  out  1  sticky saturation flag for the current run; valid with out_valid

## Operation
- States: IDLE, ACC, DONE.
- IDLE, start=1, len≠0: capture len into the counter, clear acc and ovf, go to ACC.
- IDLE, start=1, len=0: clear acc and ovf, go directly to DONE. The result is 0.
- ACC: in_ready=1. A sample is accepted when in_valid&&in_ready.
  - Each accept sets acc to sat(acc + in_data) and decrements the counter.
  - The accept that takes the counter to 0 transitions to DONE.
- DONE: out_valid=1 and out_data=acc.
  - out_ready=1 transitions to IDLE.
  - out_data is held stable while out_ready=0.
- Input normalization: a sample of negative zero (sign 1, magnitude 0) is converted to +0 before it reaches qadd.
- Addition: qadd computes a=acc and b=normalized sample.
- Overflow: the operands have equal signs and the qadd magnitude is less than the acc magnitude. In that case:
  - The stored result is that sign with magnitude 2^(N-1)-1.
  - ovf is set to 1 and stays set until the next run starts.
- Negative zero is never stored in acc.
- abort=1 in any state forces IDLE on the next edge.
  - out_valid and in_ready drop.
  - acc is not presented.
  - abort has priority over start and over the handshake in the same cycle.
- start while busy is ignored and has no side effects.
- The len port is sampled only on an accepted start.

## Timing
- Reset values: state IDLE, acc 0, counter 0, in_ready 0, out_valid 0, out_data 0, busy 0, ovf 0.
- in_ready and out_valid are registered from state (Moore outputs). They have no combinational path from in_valid or out_ready.
- start accepted at edge t: in_ready=1 from cycle t+1.
- Throughput is one sample per cycle. acc updates on the edge that accepts the sample.
- Last sample accepted at edge k:
  - in_ready=0 and out_valid=1 from cycle k+1.
  - Run latency is len+1 cycles with continuous in_valid.
- len=0: out_valid=1 one cycle after start.
- DONE with out_ready=1 at edge d:
  - IDLE at d+1.
  - A new start is accepted no earlier than d+1; there is no back-to-back run in the handoff cycle.
- in_valid gaps stall ACC indefinitely. The counter and acc hold.
- rst mid-run has the same effect as reset, regardless of state.

## Structure
- Shared package/include holds:
  - N, Q and CW defaults.
  - The state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2).
  - The SM_MAX constant (magnitude all ones).
  - The SM_NEGZERO normalization helper.
- One sub-module: the existing `qadd` with parameters Q and N passed through. It is the block's only arithmetic resource.
- Saturation and overflow detection are local combinational logic on the qadd output.

## Test plan
- **Basic run:** start with len=3, then samples 0x00008000 (+1.0), 0x00004000 (+0.5), 0x8000C000 (−1.5), each with in_valid → out_valid 4 cycles after start, out_data 0x00000000 (+0, not −0), ovf=0.
- **Zero length:** start with len=0 → out_valid next cycle, out_data 0, ovf=0, in_ready never asserted.
- **Saturation:** len=2 with 0x7FFFFFFF then 0x00000001 → out_data 0x7FFFFFFF, ovf=1. Repeat with 0xFFFFFFFF and 0x80000001 → out_data 0xFFFFFFFF, ovf=1.
- **Backpressure and stalls:**
  - len=4 with in_valid toggling 1,0,0,1,1,0,1 → 4 accepts, the sum of the accepted samples only.
  - Hold out_ready=0 for 5 cycles → out_data stable.
  - A start pulsed during the stall is ignored.
- **Abort and reset:**
  - abort after 2 of len=5 samples → IDLE next cycle, no out_valid.
  - The following run of len=1 with 0x80000000 (−0) → out_data 0x00000000, ovf=0.
  - rst asserted in DONE → all outputs at reset values next cycle.
